// File: rtl/quad_debounce_pkg.sv
// Shared constants and sizing helpers for the quadrature input debouncer.
package quad_debounce_pkg;

  // Default tuning for a typical mechanical rotary encoder on a fast clk.
  localparam int unsigned DEB_SYNC_STAGES  = 2;
  localparam int unsigned DEB_PRESCALE     = 1;
  localparam int unsigned DEB_STABLE_COUNT = 4;

  // Channel index of each encoder phase within the in/out vectors.
  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;

  // Stability counter width: must hold 0..STABLE_COUNT-1 (sized for 0..STABLE_COUNT).
  function automatic int unsigned deb_cnt_width(input int unsigned stable_count);
    return (stable_count < 1) ? 1 : $clog2(stable_count + 1);
  endfunction

  // Prescaler width: must hold 0..PRESCALE-1, at least one bit.
  function automatic int unsigned deb_pre_width(input int unsigned prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/quad_debounce_channel.sv
// One debounced input bit: synchroniser, stability counter and edge strobes.
module debounce_channel
  import quad_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEB_SYNC_STAGES,
  parameter int unsigned STABLE_COUNT = DEB_STABLE_COUNT,
  parameter int unsigned CNT_WIDTH    = deb_cnt_width(DEB_STABLE_COUNT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_in,
  output logic o_out,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync;
  logic w_differ;
  logic w_accept;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_out;
  assign w_accept = i_tick & w_differ & (r_cnt == CNT_LAST);

  // Plain flop chain bringing the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  // Qualify a new level over consecutive ticks; any agreeing sample restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (i_tick) begin
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_out <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Strobes share the update edge with out, so they line up with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept &  w_sync;
      r_fall <= w_accept & ~w_sync;
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/quad_debounce.sv
// Encoder A/B input conditioning: shared sample prescaler plus per-channel debouncers.
module quad_debounce
  import quad_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SYNC_STAGES  = DEB_SYNC_STAGES,
  parameter int unsigned PRESCALE     = DEB_PRESCALE,
  parameter int unsigned STABLE_COUNT = DEB_STABLE_COUNT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int unsigned CNT_WIDTH = deb_cnt_width(STABLE_COUNT);
  localparam int unsigned PRE_W     = deb_pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic [PRE_W-1:0] w_pre_nxt;

  assign w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);

  // tick is registered from the next count so it is low in reset yet still
  // coincides with the count sitting at PRESCALE-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_tick <= (w_pre_nxt == PRE_LAST);
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_COUNT (STABLE_COUNT),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tick  (r_tick),
      .i_in    (in[g]),
      .o_out   (out[g]),
      .o_rise  (rise[g]),
      .o_fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_quad_debounce.sv
// Directed bench for quad_debounce with a due-cycle scoreboard of expected outputs.
module tb_quad_debounce;
  import quad_debounce_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] in_a, out_a, rise_a, fall_a;
  logic       tick_a;
  logic [1:0] in_p, out_p, rise_p, fall_p;
  logic       tick_p;

  always #5 clk = ~clk;

  quad_debounce u_dut (
    .clk(clk), .reset_n(reset_n), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
  );

  quad_debounce #(.PRESCALE(4)) u_dut_p (
    .clk(clk), .reset_n(reset_n), .in(in_p),
    .out(out_p), .rise(rise_p), .fall(fall_p), .tick(tick_p)
  );

  typedef struct {
    string       tag;
    int unsigned due;
    logic [1:0]  o;
    logic [1:0]  r;
    logic [1:0]  f;
  } exp_t;

  exp_t        q[$];
  int unsigned ecnt  = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Insert keeping the queue ordered by due edge.
  task automatic push(input string tag, input int unsigned due,
                      input logic [1:0] o, input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    int   idx;
    e.tag = tag; e.due = due; e.o = o; e.r = r; e.f = f;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].due > due) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].due <= ecnt) begin
      e = q.pop_front();
      if (e.due < ecnt) begin
        n_vec++;
        n_err++;
        $error("FAIL %s: expectation for edge %0d not checked (now %0d)", e.tag, e.due, ecnt);
      end else begin
        chk({e.tag, "/out"},  out_a,  e.o);
        chk({e.tag, "/rise"}, rise_a, e.r);
        chk({e.tag, "/fall"}, fall_a, e.f);
      end
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each.
  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      ecnt++;
      #1;
      drain();
    end
  endtask

  initial begin
    int unsigned k;
    int unsigned d;
    bit          found;

    // Reset held with inputs high: everything stays cleared.
    reset_n = 1'b0;
    in_a    = 2'b11;
    in_p    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run(1);
      chk("rst_out",    out_a,           2'b00);
      chk("rst_strobe", rise_a | fall_a, 2'b00);
      chk("rst_tick",   {1'b0, tick_a},  2'b00);
      chk("rst_p_out",  out_p,           2'b00);
      chk("rst_p_tick", {1'b0, tick_p},  2'b00);
    end
    in_a = 2'b00;
    in_p = 2'b00;
    run(1);
    reset_n = 1'b1;
    run(3);
    chk("tick_free", {1'b0, tick_a}, 2'b01);
    run(6);

    // Clean step on A: visible after the 6th edge, strobe lasts one cycle.
    k = ecnt;
    in_a[CH_A] = 1'b1;
    push("step_pre",  k + 5, 2'b00, 2'b00, 2'b00);
    push("step_edge", k + 6, 2'b01, 2'b01, 2'b00);
    push("step_post", k + 7, 2'b01, 2'b00, 2'b00);
    run(8);

    // Asynchronous reset between edges clears without waiting for clk.
    reset_n = 1'b0;
    #2;
    chk("async_out",  out_a,          2'b00);
    chk("async_rise", rise_a,         2'b00);
    chk("async_tick", {1'b0, tick_a}, 2'b00);
    in_a = 2'b00;
    run(2);
    reset_n = 1'b1;
    run(8);

    // Three-cycle glitch never qualifies.
    k = ecnt;
    in_a[CH_A] = 1'b1;
    for (int unsigned i = 1; i <= 10; i++) push("glitch3", k + i, 2'b00, 2'b00, 2'b00);
    run(3);
    in_a[CH_A] = 1'b0;
    run(7);

    // Four-cycle pulse is exactly long enough: rises, then falls back.
    k = ecnt;
    in_a[CH_A] = 1'b1;
    push("pulse4_pre",  k + 5,  2'b00, 2'b00, 2'b00);
    push("pulse4_rise", k + 6,  2'b01, 2'b01, 2'b00);
    push("pulse4_hold", k + 7,  2'b01, 2'b00, 2'b00);
    push("pulse4_last", k + 9,  2'b01, 2'b00, 2'b00);
    push("pulse4_fall", k + 10, 2'b00, 2'b00, 2'b01);
    push("pulse4_done", k + 11, 2'b00, 2'b00, 2'b00);
    run(4);
    in_a[CH_A] = 1'b0;
    run(8);

    // Bounce on B: five toggles ending high, then settle.
    k = ecnt;
    for (int unsigned i = 1; i <= 9; i++) push("bounce", k + i, 2'b00, 2'b00, 2'b00);
    push("bounce_rise", k + 10, 2'b10, 2'b10, 2'b00);
    push("bounce_hold", k + 11, 2'b10, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      in_a[CH_B] = ~in_a[CH_B];
      run(1);
    end
    run(6);

    k = ecnt;
    in_a[CH_B] = 1'b0;
    push("bfall_pre",  k + 5, 2'b10, 2'b00, 2'b00);
    push("bfall_edge", k + 6, 2'b00, 2'b00, 2'b10);
    push("bfall_post", k + 7, 2'b00, 2'b00, 2'b00);
    run(7);

    // PRESCALE=4 instance: tick period and phase-dependent latency window.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      run(1);
      if (tick_p) found = 1'b1;
    end
    chk("p4_tick_seen", {1'b0, found}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      run(1);
      chk("p4_tick_gap", {1'b0, tick_p}, 2'b00);
    end
    run(1);
    chk("p4_tick_period", {1'b0, tick_p}, 2'b01);

    run($urandom_range(0, 3));
    k = ecnt;
    in_p[CH_A] = 1'b1;
    found = 1'b0;
    d = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      run(1);
      if (out_p[CH_A]) begin
        found = 1'b1;
        d = ecnt - k;
        chk("p4_rise", rise_p, 2'b01);
      end
    end
    n_vec++;
    assert (found && d >= 15 && d <= 18) else begin
      n_err++;
      $error("FAIL p4_latency: got %0d edges (seen=%0d) expected 15..18", d, found);
    end

    // Both channels, with a reset pulse mid-qualification.
    k = ecnt;
    in_a = 2'b11;
    for (int unsigned i = 1; i <= 10; i++) push("both_wait", k + i, 2'b00, 2'b00, 2'b00);
    push("both_rise", k + 11, 2'b11, 2'b11, 2'b00);
    push("both_hold", k + 12, 2'b11, 2'b00, 2'b00);
    run(3);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(7);

    n_vec++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL sb_empty: got %0d pending expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
